// File: rtl/operand_unpacker.sv
// Input stage of the binary32 adder: splits two packed operands into fields,
// then derives magnitude order, exponent distance and special-value flags.
// One transaction takes three cycles: READY -> COMPARE -> DONE.
module operand_unpacker (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_valid_i,
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  output logic        ready_o,
  output logic        data_valid_o,
  output logic        x_sign_o,
  output logic        y_sign_o,
  output logic [7:0]  x_exp_o,
  output logic [7:0]  y_exp_o,
  output logic [22:0] x_frac_o,
  output logic [22:0] y_frac_o,
  output logic        x_greater_o,
  output logic [7:0]  exp_shift_o,
  output logic        x_infinity_o,
  output logic        y_infinity_o,
  output logic        x_nan_o,
  output logic        y_nan_o
);

  typedef enum logic [1:0] {
    READY   = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic accept;
  assign accept = (state == READY) && data_valid_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= READY;
    else       state <= state_nxt;
  end

  // Next-state logic: strobes outside READY are simply ignored
  always_comb begin
    state_nxt = state;
    case (state)
      READY:   if (data_valid_i) state_nxt = COMPARE;
      COMPARE: state_nxt = DONE;
      DONE:    state_nxt = READY;
      default: state_nxt = READY;
    endcase
  end

  // Handshake outputs depend on state only, so no path from data_valid_i
  always_comb begin
    ready_o      = (state == READY);
    data_valid_o = (state == DONE);
  end

  // Metadata is computed from the captured fields, never from x_i/y_i
  logic       x_ge;
  logic [7:0] shift;
  logic       x_exp_max, y_exp_max;

  always_comb begin
    x_ge      = (x_exp_o > y_exp_o) ||
                ((x_exp_o == y_exp_o) && (x_frac_o >= y_frac_o));
    shift     = (x_exp_o >= y_exp_o) ? (x_exp_o - y_exp_o) : (y_exp_o - x_exp_o);
    x_exp_max = (x_exp_o == 8'hFF);
    y_exp_max = (y_exp_o == 8'hFF);
  end

  // Field capture on accept, metadata update in COMPARE; everything else holds
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_sign_o     <= 1'b0;
      y_sign_o     <= 1'b0;
      x_exp_o      <= '0;
      y_exp_o      <= '0;
      x_frac_o     <= '0;
      y_frac_o     <= '0;
      x_greater_o  <= 1'b0;
      exp_shift_o  <= '0;
      x_infinity_o <= 1'b0;
      y_infinity_o <= 1'b0;
      x_nan_o      <= 1'b0;
      y_nan_o      <= 1'b0;
    end else if (accept) begin
      x_sign_o <= x_i[31];
      y_sign_o <= y_i[31];
      x_exp_o  <= x_i[30:23];
      y_exp_o  <= y_i[30:23];
      x_frac_o <= x_i[22:0];
      y_frac_o <= y_i[22:0];
    end else if (state == COMPARE) begin
      x_greater_o  <= x_ge;
      exp_shift_o  <= shift;
      x_infinity_o <= x_exp_max && (x_frac_o == '0);
      y_infinity_o <= y_exp_max && (y_frac_o == '0);
      x_nan_o      <= x_exp_max && (x_frac_o != '0);
      y_nan_o      <= y_exp_max && (y_frac_o != '0);
    end
  end

endmodule

// File: tb/tb_operand_unpacker.sv
// Randomized and directed bench for operand_unpacker against an arithmetic
// reference model of the binary32 field split and magnitude comparison.
module tb_operand_unpacker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        data_valid_i;
  logic [31:0] x_i, y_i;
  logic        ready_o, data_valid_o;
  logic        x_sign_o, y_sign_o;
  logic [7:0]  x_exp_o, y_exp_o;
  logic [22:0] x_frac_o, y_frac_o;
  logic        x_greater_o;
  logic [7:0]  exp_shift_o;
  logic        x_infinity_o, y_infinity_o, x_nan_o, y_nan_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  operand_unpacker dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_valid_i(data_valid_i),
    .x_i(x_i), .y_i(y_i), .ready_o(ready_o), .data_valid_o(data_valid_o),
    .x_sign_o(x_sign_o), .y_sign_o(y_sign_o),
    .x_exp_o(x_exp_o), .y_exp_o(y_exp_o),
    .x_frac_o(x_frac_o), .y_frac_o(y_frac_o),
    .x_greater_o(x_greater_o), .exp_shift_o(exp_shift_o),
    .x_infinity_o(x_infinity_o), .y_infinity_o(y_infinity_o),
    .x_nan_o(x_nan_o), .y_nan_o(y_nan_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: fields by shifting/masking, magnitude by comparing the 31-bit
  // unsigned magnitude (exponent:fraction orders exactly like the value).
  task automatic chk_fields(input string tag, input logic [31:0] x, input logic [31:0] y);
    chk({tag, ".xs"}, x_sign_o, x >> 31);
    chk({tag, ".ys"}, y_sign_o, y >> 31);
    chk({tag, ".xe"}, x_exp_o, (x >> 23) & 32'hFF);
    chk({tag, ".ye"}, y_exp_o, (y >> 23) & 32'hFF);
    chk({tag, ".xf"}, x_frac_o, x & 32'h7FFFFF);
    chk({tag, ".yf"}, y_frac_o, y & 32'h7FFFFF);
  endtask

  task automatic chk_meta(input string tag, input logic [31:0] x, input logic [31:0] y);
    int ex, ey, fx, fy, d;
    ex = int'((x >> 23) & 32'hFF);
    ey = int'((y >> 23) & 32'hFF);
    fx = int'(x & 32'h7FFFFF);
    fy = int'(y & 32'h7FFFFF);
    d  = (ex > ey) ? ex - ey : ey - ex;
    chk({tag, ".gt"}, x_greater_o, (x & 32'h7FFFFFFF) >= (y & 32'h7FFFFFFF));
    chk({tag, ".sh"}, exp_shift_o, d);
    chk({tag, ".xi"}, x_infinity_o, (ex == 255) && (fx == 0));
    chk({tag, ".yi"}, y_infinity_o, (ey == 255) && (fy == 0));
    chk({tag, ".xn"}, x_nan_o, (ex == 255) && (fx != 0));
    chk({tag, ".yn"}, y_nan_o, (ey == 255) && (fy != 0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".fields"}, {x_sign_o, y_sign_o, x_exp_o, y_exp_o, x_frac_o, y_frac_o}, 64'd0);
    chk({tag, ".meta"}, {x_greater_o, exp_shift_o, x_infinity_o, y_infinity_o, x_nan_o, y_nan_o}, 64'd0);
    chk({tag, ".dv"}, data_valid_o, 1'b0);
    chk({tag, ".rdy"}, ready_o, 1'b1);
  endtask

  // One transaction from READY; inputs are scrambled after acceptance
  task automatic txn(input string tag, input logic [31:0] x, input logic [31:0] y);
    chk({tag, ".rdy0"}, ready_o, 1'b1);
    data_valid_i = 1'b1; x_i = x; y_i = y;
    step();
    data_valid_i = 1'b0; x_i = $urandom; y_i = $urandom;
    chk({tag, ".rdy1"}, ready_o, 1'b0);
    chk({tag, ".dv1"}, data_valid_o, 1'b0);
    chk_fields({tag, ".c1"}, x, y);
    step();
    chk({tag, ".dv2"}, data_valid_o, 1'b1);
    chk({tag, ".rdy2"}, ready_o, 1'b0);
    chk_fields({tag, ".c2"}, x, y);
    chk_meta({tag, ".c2"}, x, y);
    step();
    chk({tag, ".dv3"}, data_valid_o, 1'b0);
    chk({tag, ".rdy3"}, ready_o, 1'b1);
    chk_fields({tag, ".c3"}, x, y);
    chk_meta({tag, ".c3"}, x, y);
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      0: v[30:23] = 8'hFF;
      1: begin v[30:23] = 8'hFF; v[22:0] = '0; end
      2: v[30:23] = 8'h00;
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] acc_q[$];
    logic [31:0] xa, ya;
    logic        prev_dv;
    int          busy;

    rst_i = 1'b1; data_valid_i = 1'b0; x_i = '0; y_i = '0;
    step(); step();
    rst_i = 1'b0;
    chk_all_zero("reset");

    txn("d_exp", 32'h3F800000, 32'h40000000);
    chk("d_exp.gt", x_greater_o, 1'b0);
    txn("d_eq", 32'h3FC00000, 32'h3F800000);
    txn("d_tie", 32'hBF800000, 32'hBF800000);
    chk("d_tie.gt", x_greater_o, 1'b1);
    txn("d_sh23", 32'h3F800000, 32'h4B000000);
    chk("d_sh23.sh", exp_shift_o, 8'd23);
    txn("d_sh253", 32'h7F000000, 32'h00800000);
    chk("d_sh253.sh", exp_shift_o, 8'd253);
    txn("d_spec", 32'h7F800000, 32'hFFC00001);
    chk("d_spec.flags", {x_infinity_o, y_nan_o, x_nan_o, y_infinity_o, y_sign_o}, 5'b11001);

    for (int i = 0; i < 40; i++) begin
      xa = rand_op();
      ya = ($urandom_range(0, 4) == 0) ? xa : rand_op();
      if ($urandom_range(0, 3) == 0) ya[30:23] = xa[30:23];
      txn("rnd", xa, ya);
    end

    // Continuous strobe: expect an accept every third cycle, each using that cycle's X
    busy = 0; prev_dv = 1'b0;
    data_valid_i = 1'b1;
    for (int k = 0; k < 30; k++) begin
      chk("cont.rdy", ready_o, busy == 0);
      chk("cont.dv", data_valid_o, busy == 1);
      chk("cont.dv_pair", prev_dv && data_valid_o, 1'b0);
      if (busy == 1) begin
        xa = acc_q.pop_front();
        ya = acc_q.pop_front();
        chk_fields("cont", xa, ya);
        chk_meta("cont", xa, ya);
      end
      prev_dv = data_valid_o;
      x_i = rand_op(); y_i = rand_op();
      if (busy == 0) begin
        acc_q.push_back(x_i); acc_q.push_back(y_i);
        busy = 2;
      end else begin
        busy--;
      end
      step();
    end
    data_valid_i = 1'b0;
    step(); step(); step();

    // Reset during COMPARE aborts the transaction
    chk("rstc.rdy0", ready_o, 1'b1);
    data_valid_i = 1'b1; x_i = 32'h40490FDB; y_i = 32'hC0000000;
    step();
    data_valid_i = 1'b0; rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk_all_zero("rstc.a");
    step();
    chk_all_zero("rstc.b");

    // Reset wins over a simultaneous strobe
    data_valid_i = 1'b1; rst_i = 1'b1; x_i = 32'h7F800000; y_i = 32'h3F800000;
    step();
    data_valid_i = 1'b0; rst_i = 1'b0;
    chk_all_zero("rstv.a");
    step();
    chk_all_zero("rstv.b");
    step();
    chk_all_zero("rstv.c");

    txn("post", 32'h3F800000, 32'h40000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
